// File: rtl/dispense_controller_if.sv
// Handshake/bus bundle between the selection controller and dispense_controller.
// master = selection side (drives requests and restock), slave = dispense stage.
interface dispense_controller_if #(
  parameter int STOCK_W = 4
) ();
  logic [1:0]         state;
  logic [3:0]         index;
  logic               cancelled;
  logic               changeStateDone;
  logic               restock_valid;
  logic [3:0]         restock_index;
  logic [STOCK_W-1:0] restock_count;
  logic               fullInventory;
  logic               changeState;
  logic               cancelledDone;
  logic               motor;
  logic [3:0]         motor_item;
  logic [15:0]        vend_total;
  logic [15:0]        abort_total;

  modport master (
    output state, index, cancelled, changeStateDone,
    output restock_valid, restock_index, restock_count,
    input  fullInventory, changeState, cancelledDone, motor, motor_item,
    input  vend_total, abort_total
  );

  modport slave (
    input  state, index, cancelled, changeStateDone,
    input  restock_valid, restock_index, restock_count,
    output fullInventory, changeState, cancelledDone, motor, motor_item,
    output vend_total, abort_total
  );
endinterface

// File: rtl/dispense_controller.sv
// Vend stage: per-slot stock, timed motor drive, changeState/cancelled handshakes.
// Optional audit counters (vend_total/abort_total) built when DISPENSE_AUDIT_EN is defined.
//
// state    | meaning
// S_IDLE   | waiting for dispense request or cancel
// S_VEND   | motor on, timer counting down to zero
// S_REQ    | changeState high, waiting for changeStateDone
// S_ACK    | waiting for changeStateDone to drop
// S_CANCEL | cancelledDone high, waiting for cancelled to drop
module dispense_controller #(
  parameter int NUM_ITEMS       = 16,
  parameter int STOCK_W         = 4,
  parameter int INIT_STOCK      = 5,
  parameter int DISPENSE_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  dispense_controller_if.slave  bus
);

  localparam logic [STOCK_W-1:0] STOCK_MAX = '1;
  localparam int                 TMR_W     = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;
  localparam logic [4:0]         ITEMS_LIM = 5'(NUM_ITEMS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VEND,
    S_REQ,
    S_ACK,
    S_CANCEL
  } state_t;

  state_t             r_fsm;
  state_t             w_fsm_nxt;
  logic [TMR_W-1:0]   r_timer;
  logic [3:0]         r_motor_item;
  logic [STOCK_W-1:0] r_stock     [NUM_ITEMS];
  logic [STOCK_W-1:0] w_stock_nxt [NUM_ITEMS];
  logic               r_full;

  logic               w_idx_ok;
  logic               w_rs_ok;
  logic [STOCK_W-1:0] w_sel_stock;
  logic               w_start;
  logic               w_vend_done;
  logic               w_abort;
  logic [STOCK_W:0]   w_sum;

  assign w_idx_ok = {1'b0, bus.index} < ITEMS_LIM;
  assign w_rs_ok  = {1'b0, bus.restock_index} < ITEMS_LIM;

  always_comb begin
    w_sel_stock = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (bus.index == 4'(i)) w_sel_stock = r_stock[i];
    end
  end

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_start     = 1'b0;
    w_vend_done = 1'b0;
    w_abort     = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        if (bus.cancelled) begin
          w_fsm_nxt = S_CANCEL;
        end else if (bus.state == 2'b01 && w_idx_ok && w_sel_stock != '0) begin
          w_start   = 1'b1;
          w_fsm_nxt = S_VEND;
        end
      end
      S_VEND: begin
        // cancel takes priority over a timer expiring on the same edge
        if (bus.cancelled) begin
          w_abort   = 1'b1;
          w_fsm_nxt = S_CANCEL;
        end else if (r_timer == '0) begin
          w_vend_done = 1'b1;
          w_fsm_nxt   = S_REQ;
        end
      end
      S_REQ:    if (bus.changeStateDone)  w_fsm_nxt = S_ACK;
      S_ACK:    if (!bus.changeStateDone) w_fsm_nxt = S_IDLE;
      S_CANCEL: if (!bus.cancelled)       w_fsm_nxt = S_IDLE;
      default:  w_fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm        <= S_IDLE;
      r_timer      <= '0;
      r_motor_item <= '0;
      r_full       <= 1'b0;
    end else begin
      r_fsm  <= w_fsm_nxt;
      r_full <= w_idx_ok && (w_sel_stock != '0);
      if (w_start) begin
        r_timer      <= TMR_W'(DISPENSE_CYCLES - 1);
        r_motor_item <= bus.index;
      end else if (r_fsm == S_VEND && r_timer != '0) begin
        r_timer <= r_timer - 1'b1;
      end
    end
  end

  // Decrement and restock can hit the same slot on one edge; sum first, then saturate.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      w_sum = {1'b0, r_stock[i]};
      if (bus.restock_valid && w_rs_ok && bus.restock_index == 4'(i))
        w_sum = w_sum + {1'b0, bus.restock_count};
      if (w_vend_done && r_motor_item == 4'(i))
        w_sum = w_sum - {{STOCK_W{1'b0}}, 1'b1};
      w_stock_nxt[i] = (w_sum > {1'b0, STOCK_MAX}) ? STOCK_MAX : w_sum[STOCK_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (rst) r_stock[i] <= STOCK_W'(INIT_STOCK);
      else     r_stock[i] <= w_stock_nxt[i];
    end
  end

  assign bus.fullInventory = r_full;
  assign bus.changeState   = (r_fsm == S_REQ);
  assign bus.cancelledDone = (r_fsm == S_CANCEL);
  assign bus.motor         = (r_fsm == S_VEND);
  assign bus.motor_item    = r_motor_item;

`ifdef DISPENSE_AUDIT_EN
  logic [15:0] r_vend_total;
  logic [15:0] r_abort_total;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vend_total  <= '0;
      r_abort_total <= '0;
    end else begin
      if (w_vend_done) r_vend_total  <= r_vend_total + 16'd1;
      if (w_abort)     r_abort_total <= r_abort_total + 16'd1;
    end
  end

  assign bus.vend_total  = r_vend_total;
  assign bus.abort_total = r_abort_total;
`else
  assign bus.vend_total  = '0;
  assign bus.abort_total = '0;
`endif

endmodule

// File: tb/tb_dispense_controller.sv
// Self-checking bench for dispense_controller: scoreboard of expected motor runs
// plus a stock/counter model compared against the design.
module tb_dispense_controller;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dispense_controller_if #(.STOCK_W(4)) bus ();

  dispense_controller #(
    .NUM_ITEMS(16), .STOCK_W(4), .INIT_STOCK(5), .DISPENSE_CYCLES(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  typedef struct {
    int item;
    int dur;
    bit cs;
  } vend_t;

  vend_t sb[$];
  int    m_stock[16];
  int    m_vends;
  int    m_aborts;

  function automatic int audit(input int v);
`ifdef DISPENSE_AUDIT_EN
    return v & 32'hffff;
`else
    return 0 * v;
`endif
  endfunction

  // Motor monitor: measures each motor run and pops the matching expectation when it ends.
  initial begin : mon
    bit    prev;
    int    run;
    int    item;
    vend_t e;
    prev = 1'b0;
    run  = 0;
    item = 0;
    forever begin
      @(negedge clk);
      if (bus.motor) begin
        if (!prev) begin
          run  = 1;
          item = bus.motor_item;
        end else begin
          run++;
        end
      end else if (prev) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_run", run, 0);
        end else begin
          e = sb.pop_front();
          check("motor_item", item, e.item);
          check("motor_cycles", run, e.dur);
          check("cs_at_motor_fall", bus.changeState, e.cs);
        end
      end
      prev = bus.motor;
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_stock[i] = 5;
    m_vends  = 0;
    m_aborts = 0;
  endtask

  task automatic check_all();
    for (int i = 0; i < 16; i++)
      check($sformatf("stock%0d", i), 32'(dut.r_stock[i]), m_stock[i]);
    check("vend_total", bus.vend_total, audit(m_vends));
    check("abort_total", bus.abort_total, audit(m_aborts));
  endtask

  task automatic wait_motor(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.motor) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_vend(input int idx, input bit ok_exp, input int rs_cnt);
    bit ok;
    int n;
    int m;
    bus.index = 4'(idx);
    bus.state = 2'b01;
    if (!ok_exp) begin
      repeat (3) begin
        @(negedge clk);
        check("motor_no_stock", bus.motor, 0);
      end
      bus.state = 2'b00;
      return;
    end
    sb.push_back('{idx, D, 1'b1});
    wait_motor(ok);
    check("vend_start", ok, 1);
    bus.state = 2'b00;
    if (!ok) return;
    n = 1;
    while (bus.motor && n < 40) begin
      if (n == D && rs_cnt > 0) begin
        bus.restock_valid = 1'b1;
        bus.restock_index = 4'(idx);
        bus.restock_count = 4'(rs_cnt);
      end
      @(negedge clk);
      bus.restock_valid = 1'b0;
      n++;
    end
    check("cs_rise", bus.changeState, 1);
    m = m_stock[idx] - 1 + rs_cnt;
    m_stock[idx] = (m > 15) ? 15 : m;
    m_vends++;
    bus.changeStateDone = 1'b1;
    @(negedge clk);
    check("cs_fall", bus.changeState, 0);
    bus.changeStateDone = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_restock(input int idx, input int cnt);
    int m;
    bus.restock_valid = 1'b1;
    bus.restock_index = 4'(idx);
    bus.restock_count = 4'(cnt);
    @(negedge clk);
    bus.restock_valid = 1'b0;
    m = m_stock[idx] + cnt;
    m_stock[idx] = (m > 15) ? 15 : m;
  endtask

  task automatic cancel_vend(input int idx, input int k);
    bit ok;
    bus.index = 4'(idx);
    bus.state = 2'b01;
    sb.push_back('{idx, k, 1'b0});
    wait_motor(ok);
    check("cancel_vend_start", ok, 1);
    bus.state = 2'b00;
    repeat (k - 1) @(negedge clk);
    bus.cancelled = 1'b1;
    @(negedge clk);
    check("cancel_motor_off", bus.motor, 0);
    check("cancelledDone_rise", bus.cancelledDone, 1);
    m_aborts++;
    bus.cancelled = 1'b0;
    @(negedge clk);
    check("cancelledDone_fall", bus.cancelledDone, 0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit ok;
    rst                 = 1'b1;
    bus.state           = 2'b00;
    bus.index           = 4'd3;
    bus.cancelled       = 1'b0;
    bus.changeStateDone = 1'b0;
    bus.restock_valid   = 1'b0;
    bus.restock_index   = 4'd0;
    bus.restock_count   = 4'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_motor", bus.motor, 0);
    check("rst_changeState", bus.changeState, 0);
    check("rst_cancelledDone", bus.cancelledDone, 0);
    check("rst_full", bus.fullInventory, 0);
    rst = 1'b0;
    @(negedge clk);
    check("full_idx3", bus.fullInventory, 1);
    check_all();

    do_vend(3, 1'b1, 0);
    check_all();

    for (int i = 0; i < 5; i++) do_vend(2, 1'b1, 0);
    bus.index = 4'd2;
    @(negedge clk);
    @(negedge clk);
    check("full_slot2_empty", bus.fullInventory, 0);
    do_vend(2, 1'b0, 0);
    check_all();

    cancel_vend(5, 4);
    check_all();

    do_restock(7, 15);
    do_vend(7, 1'b1, 0);
    do_vend(7, 1'b1, 2);
    check_all();

    do_restock(2, 3);
    bus.index = 4'd2;
    @(negedge clk);
    @(negedge clk);
    check("full_slot2_restocked", bus.fullInventory, 1);

    bus.index = 4'd4;
    bus.state = 2'b01;
    sb.push_back('{4, 3, 1'b0});
    wait_motor(ok);
    check("rstvend_start", ok, 1);
    bus.state = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_motor", bus.motor, 0);
    check("rst_mid_changeState", bus.changeState, 0);
    rst = 1'b0;
    model_reset();
    check_all();

    @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
